// File: rtl/lut_layer_scheduler_if.sv
// rtl/lut_layer_scheduler_if.sv - stream and table-config bundle for lut_layer_scheduler
//
// Purpose: groups the input frame stream, the output frame stream and the
//   truth-table write port of the layer scheduler.
// Signals:
//   s_valid/s_ready/s_data   fan-in frame, neuron k = s_data[k*IN_BITS +: IN_BITS]
//   m_valid/m_ready/m_data   layer result, neuron k = m_data[k*OUT_BITS +: OUT_BITS]
//   cfg_we/cfg_ready         table write strobe / write accepted
//   cfg_addr                 {neuron index, input pattern}
//   cfg_wdata                table entry
// Modports: master = host/bench side, slave = scheduler side.
interface lut_layer_scheduler_if #(
  parameter int NUM_NEURONS = 8,
  parameter int IN_BITS     = 4,
  parameter int OUT_BITS    = 2
);
  localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int ADDR_W = IDX_W + IN_BITS;

  logic                            s_valid;
  logic                            s_ready;
  logic [NUM_NEURONS*IN_BITS-1:0]  s_data;
  logic                            m_valid;
  logic                            m_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] m_data;
  logic                            cfg_we;
  logic [ADDR_W-1:0]               cfg_addr;
  logic [OUT_BITS-1:0]             cfg_wdata;
  logic                            cfg_ready;

  modport master (
    output s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_wdata,
    input  s_ready, m_valid, m_data, cfg_ready
  );

  modport slave (
    input  s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_wdata,
    output s_ready, m_valid, m_data, cfg_ready
  );
endinterface

// File: rtl/lut_layer_scheduler.sv
// rtl/lut_layer_scheduler.sv - time-multiplexed LUT evaluator for one sparse layer
//
// Purpose: one shared truth-table RAM serves all NUM_NEURONS neurons. A captured
//   fan-in frame is evaluated one neuron per cycle, then the packed layer result
//   is held until the downstream stage accepts it.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (tables are not cleared)
//   bus          lut_layer_scheduler_if.slave (frame in, frame out, table writes)
//   perf_frames  completed-frame counter, saturating; present only when
//                LUT_SCHED_PERF_EN is defined
// Optional feature macro: LUT_SCHED_PERF_EN
module lut_layer_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int IN_BITS     = 4,
  parameter int OUT_BITS    = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef LUT_SCHED_PERF_EN
  output logic [31:0] perf_frames,
`endif
  lut_layer_scheduler_if.slave bus
);
  localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int ADDR_W = IDX_W + IN_BITS;
  localparam int DEPTH  = NUM_NEURONS * (2 ** IN_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam bit   POW2_N = ((1 << IDX_W) == NUM_NEURONS);

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_DONE} state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic [NUM_NEURONS*IN_BITS-1:0]  r_in_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] r_m_data;
  logic                            r_m_valid;
  logic [OUT_BITS-1:0]             r_table [DEPTH];

  logic                            w_s_ready;
  logic                            w_cfg_ready;
  logic                            w_accept;
  logic                            w_last;
  logic                            w_done_ack;
  logic                            w_cfg_in_range;
  logic                            w_cfg_take;
  logic [IN_BITS-1:0]              w_pattern;
  logic [ADDR_W-1:0]               w_rd_addr;
  logic [OUT_BITS-1:0]             w_rd_data;

  // Asynchronous table read for the neuron currently being evaluated.
  assign w_pattern = r_in_q[r_idx*IN_BITS +: IN_BITS];
  assign w_rd_addr = {r_idx, w_pattern};
  assign w_rd_data = r_table[w_rd_addr];

  // Neuron index field can only exceed the layer when NUM_NEURONS is not a power of two.
  generate
    if (POW2_N) begin : g_cfg_range_pow2
      assign w_cfg_in_range = 1'b1;
    end else begin : g_cfg_range_np2
      localparam logic [IDX_W:0] NEURON_LIM = (IDX_W + 1)'(NUM_NEURONS);
      assign w_cfg_in_range = ({1'b0, bus.cfg_addr[ADDR_W-1:IN_BITS]} < NEURON_LIM);
    end
  endgenerate

  // Writes are only taken in IDLE, so the table never changes under a running frame.
  assign w_cfg_take = bus.cfg_we & w_cfg_ready & w_cfg_in_range;

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_cfg_ready = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_done_ack  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready   = 1'b1;
        w_cfg_ready = 1'b1;
        if (bus.s_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.m_ready) begin
          w_done_ack  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_in_q    <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_in_q <= bus.s_data;
        r_idx  <= '0;
      end
      if (r_state == ST_EVAL) begin
        // Slices not yet reached keep the previous frame's values.
        r_m_data[r_idx*OUT_BITS +: OUT_BITS] <= w_rd_data;
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_last) begin
        r_m_valid <= 1'b1;
      end else if (w_done_ack) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // Table RAM has no reset so programmed contents survive rst.
  always_ff @(posedge clk) begin
    if (w_cfg_take) begin
      r_table[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.cfg_ready = w_cfg_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;

`ifdef LUT_SCHED_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if (w_done_ack && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_frames = r_perf;
`endif
endmodule

// File: tb/tb_lut_layer_scheduler.sv
// tb/tb_lut_layer_scheduler.sv - directed vector bench for lut_layer_scheduler
module tb_lut_layer_scheduler;
  logic clk;
  logic rst;
`ifdef LUT_SCHED_PERF_EN
  logic [31:0] perf_frames;
`endif

  lut_layer_scheduler_if #(.NUM_NEURONS(8), .IN_BITS(4), .OUT_BITS(2)) bus ();

  lut_layer_scheduler #(.NUM_NEURONS(8), .IN_BITS(4), .OUT_BITS(2)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef LUT_SCHED_PERF_EN
    .perf_frames (perf_frames),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s_data;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [9];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [6:0] a, input logic [1:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.m_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] d, output logic [15:0] got);
    int lat;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
    wait_valid(lat);
    check("latency", lat, 8);
    got = bus.m_data;
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] first;
    logic        ok;
    int          lat;

    vecs[0] = '{32'h0000_0001, 16'h0003};
    vecs[1] = '{32'h1234_5678, 16'h0001};
    vecs[2] = '{32'hFFFF_FFFD, 16'h0002};
    vecs[3] = '{32'h0000_000F, 16'h0001};
    vecs[4] = '{32'hABCD_EF00, 16'h0000};
    vecs[5] = '{32'h0000_0005, 16'h0000};
    vecs[6] = '{32'h7654_3210, 16'hAAAA};
    vecs[7] = '{32'h8765_4321, 16'h5555};
    vecs[8] = '{32'hF6F4_F2F0, 16'h6666};

    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("reset_m_data", {16'd0, bus.m_data}, 32'd0);
    check("reset_s_ready", {31'd0, bus.s_ready}, 32'd1);
    check("reset_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);

    // Phase A: all tables zero, neuron 0 programmed with a sparse pattern set.
    for (int i = 0; i < 128; i++) cfg_write(7'(i), 2'b00);
    cfg_write({3'd0, 4'b1000}, 2'b01);
    cfg_write({3'd0, 4'b0001}, 2'b11);
    cfg_write({3'd0, 4'b1101}, 2'b10);
    cfg_write({3'd0, 4'b1111}, 2'b01);
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].s_data, got);
      check($sformatf("vecA%0d", i), {16'd0, got}, {16'd0, vecs[i].exp_data});
    end

    // Phase B: neuron k maps pattern k to 10, everything else to 01.
    for (int k = 0; k < 8; k++)
      for (int p = 0; p < 16; p++)
        cfg_write({3'(k), 4'(p)}, (p == k) ? 2'b10 : 2'b01);
    for (int i = 6; i < 9; i++) begin
      run_frame(vecs[i].s_data, got);
      check($sformatf("vecB%0d", i), {16'd0, got}, {16'd0, vecs[i].exp_data});
    end

    // Backpressure in DONE with a second frame already waiting.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h7654_3210;
    tick();
    bus.s_data  = 32'h8765_4321;
    wait_valid(lat);
    check("hold_latency", lat, 8);
    first = bus.m_data;
    check("hold_first", {16'd0, first}, 32'h0000_AAAA);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.m_valid !== 1'b1 || bus.m_data !== first || bus.s_ready !== 1'b0) ok = 1'b0;
    end
    check("hold_stable", {31'd0, ok}, 32'd1);
    consume();
    check("hold_release_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("hold_release_s_ready", {31'd0, bus.s_ready}, 32'd1);
    tick();
    bus.s_valid = 1'b0;
    wait_valid(lat);
    check("hold_second_latency", lat, 8);
    check("hold_second_data", {16'd0, bus.m_data}, 32'h0000_5555);
    consume();

    // Table write attempted during EVAL is dropped.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h7654_3210;
    tick();
    bus.s_valid = 1'b0;
    check("eval_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
    cfg_write({3'd3, 4'd3}, 2'b00);
    wait_valid(lat);
    check("eval_write_latency", lat, 7);
    consume();
    run_frame(32'h7654_3210, got);
    check("eval_write_dropped", {16'd0, got}, 32'h0000_AAAA);

    // Reset in the middle of EVAL (idx=4) discards the frame, tables survive.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h8765_4321;
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("midrst_m_data", {16'd0, bus.m_data}, 32'd0);
    check("midrst_s_ready", {31'd0, bus.s_ready}, 32'd1);
    run_frame(32'h7654_3210, got);
    check("midrst_tables_kept", {16'd0, got}, 32'h0000_AAAA);

    // Table write and frame accepted on the same IDLE edge.
    bus.s_valid   = 1'b1;
    bus.s_data    = 32'h0000_0000;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = {3'd0, 4'd0};
    bus.cfg_wdata = 2'b11;
    tick();
    bus.s_valid   = 1'b0;
    bus.cfg_we    = 1'b0;
    wait_valid(lat);
    check("same_edge_latency", lat, 8);
    check("same_edge_data", {16'd0, bus.m_data}, 32'h0000_5557);
    consume();
    cfg_write({3'd0, 4'd0}, 2'b10);

`ifdef LUT_SCHED_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_reset", perf_frames, 32'd0);
    run_frame(32'h7654_3210, got);
    run_frame(32'h8765_4321, got);
    run_frame(32'hF6F4_F2F0, got);
    check("perf_three", perf_frames, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_cleared", perf_frames, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
